// File: rtl/ioblock_cfg_pkg.sv
// Shared definitions for the I/O block configuration controller:
// FSM state encodings, TSMUX mode constants and the per-slot config record.
package ioblock_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OFF    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_APPLY  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [1:0] TSMUX_OFF = 2'b00;
    localparam logic [1:0] TSMUX_TS  = 2'b01;
    localparam logic [1:0] TSMUX_ON  = 2'b10;

    // One I/O block's configuration bits as held by the controller.
    typedef struct packed {
        logic [1:0] tsmux;
        logic       dorreg;
    } slot_cfg_t;

endpackage

// File: rtl/ioblock_cfg_regfile.sv
// Slot store for NBLK I/O blocks: one indexed write port, one indexed
// read port, and flattened TSMUX/DORREG buses driving the I/O ring.
module ioblock_cfg_regfile
    import ioblock_cfg_pkg::*;
#(
    parameter  int NBLK = 8,
    localparam int IDXW = $clog2(NBLK)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDXW-1:0]   waddr_i,
    input  slot_cfg_t         wdata_i,
    input  logic [IDXW-1:0]   raddr_i,
    output slot_cfg_t         rdata_o,
    output logic [2*NBLK-1:0] tsmux_bus_o,
    output logic [NBLK-1:0]   dorreg_bus_o
);

    slot_cfg_t slot_q [NBLK];

    // Slot storage: reset to the I/O block power-up state, write only the addressed slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NBLK; i++) begin
                slot_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NBLK; i++) begin
                if (IDXW'(i) == waddr_i) begin
                    slot_q[i] <= wdata_i;
                end
            end
        end
    end

    // Read mux; an out-of-range address reads as all-zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NBLK; i++) begin
            if (IDXW'(i) == raddr_i) begin
                rdata_o = slot_q[i];
            end
        end
    end

    // Flatten the slots onto the per-block config buses.
    always_comb begin
        tsmux_bus_o  = '0;
        dorreg_bus_o = '0;
        for (int i = 0; i < NBLK; i++) begin
            tsmux_bus_o[2*i +: 2] = slot_q[i].tsmux;
            dorreg_bus_o[i]       = slot_q[i].dorreg;
        end
    end

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// Sequenced configuration controller for a bank of I/O blocks. A driving
// pad is forced to TSMUX=00 for SETTLE cycles before its new mode lands,
// so a pad never switches directly between two drive modes.
module ioblock_cfg_ctrl
    import ioblock_cfg_pkg::*;
#(
    parameter  int NBLK   = 8,
    parameter  int SETTLE = 4,
    localparam int IDXW   = $clog2(NBLK)
) (
    input  logic              IOCLK,
    input  logic              RST_N,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [IDXW-1:0]   CFG_IDX,
    input  logic [1:0]        CFG_TSMUX,
    input  logic              CFG_DORREG,
    output logic [2*NBLK-1:0] TSMUX_BUS,
    output logic [NBLK-1:0]   DORREG_BUS,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int             CNTW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE - 1);

    state_e            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic [IDXW-1:0]   idx_q;
    slot_cfg_t         req_q;

    slot_cfg_t         req_d;
    slot_cfg_t         cur_cfg;
    slot_cfg_t         wdata_d;
    logic [IDXW-1:0]   raddr_d;
    logic              we_d;
    logic              idx_ok;

    assign req_d  = '{tsmux: CFG_TSMUX, dorreg: CFG_DORREG};
    assign idx_ok = ({{(32-IDXW){1'b0}}, CFG_IDX} < 32'(NBLK));

    // Read the incoming target while idle, the captured target otherwise;
    // OFF clears only TSMUX and keeps the slot's current DORREG.
    always_comb begin
        raddr_d = (state_q == ST_IDLE) ? CFG_IDX : idx_q;
        we_d    = (state_q == ST_OFF) || (state_q == ST_APPLY);
        wdata_d = req_q;
        if (state_q == ST_OFF) begin
            wdata_d = '{tsmux: TSMUX_OFF, dorreg: cur_cfg.dorreg};
        end
    end

    ioblock_cfg_regfile #(
        .NBLK (NBLK)
    ) u_regfile (
        .clk_i        (IOCLK),
        .rst_ni       (RST_N),
        .we_i         (we_d),
        .waddr_i      (idx_q),
        .wdata_i      (wdata_d),
        .raddr_i      (raddr_d),
        .rdata_o      (cur_cfg),
        .tsmux_bus_o  (TSMUX_BUS),
        .dorreg_bus_o (DORREG_BUS)
    );

    // Request capture on the handshake edge; contents are don't-care until then.
    always_ff @(posedge IOCLK) begin
        if (state_q == ST_IDLE && CFG_VALID) begin
            idx_q <= CFG_IDX;
            req_q <= req_d;
        end
    end

    // Sequencing FSM with settle counter; reset aborts any request in flight.
    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CFG_VALID) begin
                        if (!idx_ok) begin
                            state_q <= ST_ERR;
                        end else if (cur_cfg == req_d) begin
                            state_q <= ST_DONE;
                        end else if (cur_cfg.tsmux == TSMUX_OFF) begin
                            state_q <= ST_APPLY;
                        end else begin
                            state_q <= ST_OFF;
                        end
                    end
                end
                ST_OFF: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_APPLY;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                ST_APPLY: state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                ST_ERR:   state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign CFG_READY = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_DONE);
    assign ERR       = (state_q == ST_ERR);

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Directed bench for ioblock_cfg_ctrl: main instance at NBLK=8/SETTLE=4,
// second instance at NBLK=6 to reach the out-of-range index path.
module tb_ioblock_cfg_ctrl;
    import ioblock_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance, NBLK=8
    logic        v0;
    logic [2:0]  idx0;
    logic [1:0]  ts0;
    logic        dor0;
    logic        rdy0, busy0, done0, err0;
    logic [15:0] tsb0;
    logic [7:0]  dorb0;

    // Second instance, NBLK=6
    logic        v1;
    logic [2:0]  idx1;
    logic [1:0]  ts1;
    logic        dor1;
    logic        rdy1, busy1, done1, err1;
    logic [11:0] tsb1;
    logic [5:0]  dorb1;

    int errs   = 0;
    int checks = 0;

    ioblock_cfg_ctrl #(.NBLK(8), .SETTLE(4)) dut0 (
        .IOCLK(clk), .RST_N(rst_n), .CFG_VALID(v0), .CFG_READY(rdy0),
        .CFG_IDX(idx0), .CFG_TSMUX(ts0), .CFG_DORREG(dor0),
        .TSMUX_BUS(tsb0), .DORREG_BUS(dorb0),
        .BUSY(busy0), .DONE(done0), .ERR(err0)
    );

    ioblock_cfg_ctrl #(.NBLK(6), .SETTLE(4)) dut1 (
        .IOCLK(clk), .RST_N(rst_n), .CFG_VALID(v1), .CFG_READY(rdy1),
        .CFG_IDX(idx1), .CFG_TSMUX(ts1), .CFG_DORREG(dor1),
        .TSMUX_BUS(tsb1), .DORREG_BUS(dorb1),
        .BUSY(busy1), .DONE(done1), .ERR(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy0;
        int n = 0;
        while (!rdy0 && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) chk("rdy0_timeout", rdy0, 1);
    endtask

    task automatic wait_rdy1;
        int n = 0;
        while (!rdy1 && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) chk("rdy1_timeout", rdy1, 1);
    endtask

    // Returns just after the handshake edge t.
    task automatic req0(input logic [2:0] i, input logic [1:0] t, input logic d);
        wait_rdy0;
        v0 = 1'b1; idx0 = i; ts0 = t; dor0 = d;
        tick;
        v0 = 1'b0;
    endtask

    task automatic req1(input logic [2:0] i, input logic [1:0] t, input logic d);
        wait_rdy1;
        v1 = 1'b1; idx1 = i; ts1 = t; dor1 = d;
        tick;
        v1 = 1'b0;
    endtask

    initial begin
        logic [2:0] hi [3];
        logic [1:0] ht [3];
        logic       hd [3];
        int         nd;
        int         n;
        logic [2:0] iv;

        hi = '{3'd5, 3'd5, 3'd0};
        ht = '{TSMUX_ON, TSMUX_ON, TSMUX_TS};
        hd = '{1'b1, 1'b0, 1'b1};

        // Reset with a request presented; it must be ignored.
        rst_n = 1'b0;
        v0 = 1'b1; idx0 = 3'd1; ts0 = TSMUX_ON; dor0 = 1'b1;
        v1 = 1'b0; idx1 = '0; ts1 = '0; dor1 = 1'b0;
        tick; tick;
        chk("rst_tsmux", tsb0, 16'h0000);
        chk("rst_dorreg", dorb0, 8'h00);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        rst_n = 1'b1;
        v0 = 1'b0;
        #1;
        chk("rst_ready", rdy0, 1);
        tick;
        chk("post_rst_tsmux", tsb0, 16'h0000);

        // Out-of-range index on the NBLK=6 instance, after programming slot 5.
        req1(3'd5, TSMUX_ON, 1'b1);
        tick;
        chk("d1_slot5_ts", tsb1, 12'h800);
        chk("d1_slot5_dor", dorb1, 6'h20);
        tick;
        req1(3'd7, TSMUX_TS, 1'b1);
        chk("err_pulse", err1, 1);
        chk("err_no_done", done1, 0);
        chk("err_ts_hold", tsb1, 12'h800);
        tick;
        chk("err_one_cycle", err1, 0);
        chk("err_ready", rdy1, 1);
        chk("err_ts_after", tsb1, 12'h800);
        chk("err_dor_after", dorb1, 6'h20);

        // Slot 3 already off: applied after t+1.
        req0(3'd3, TSMUX_ON, 1'b1);
        chk("off_busy", busy0, 1);
        chk("off_ready_low", rdy0, 0);
        tick;
        chk("off_apply_ts", tsb0, 16'h0080);
        chk("off_apply_dor", dorb0, 8'h08);
        chk("off_done", done0, 1);
        tick;
        chk("off_done_end", done0, 0);
        chk("off_ready", rdy0, 1);

        // Slot 3 driving: OFF, 4 settle cycles, then new config.
        req0(3'd3, TSMUX_TS, 1'b0);
        tick;
        chk("full_off_ts", tsb0, 16'h0000);
        chk("full_off_dor", dorb0, 8'h08);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("full_settle_ts", tsb0, 16'h0000);
            chk("full_settle_done", done0, 0);
        end
        tick;
        chk("full_new_ts", tsb0, 16'h0040);
        chk("full_new_dor", dorb0, 8'h00);
        chk("full_done", done0, 1);
        tick;
        chk("full_done_end", done0, 0);
        chk("full_ready", rdy0, 1);

        // Identical config: DONE right after t, no off interval.
        req0(3'd3, TSMUX_TS, 1'b0);
        chk("same_done", done0, 1);
        chk("same_ts", tsb0, 16'h0040);
        tick;
        chk("same_done_end", done0, 0);
        chk("same_ready", rdy0, 1);
        chk("same_ts_after", tsb0, 16'h0040);

        // Valid held high through BUSY with the next request already presented.
        wait_rdy0;
        v0 = 1'b1; idx0 = hi[0]; ts0 = ht[0]; dor0 = hd[0];
        for (int k = 0; k < 3; k++) begin
            tick;
            if (k < 2) begin
                idx0 = hi[k+1]; ts0 = ht[k+1]; dor0 = hd[k+1];
            end else begin
                v0 = 1'b0;
            end
            nd = 0;
            n  = 0;
            while (!rdy0 && n < 50) begin
                if (done0) nd++;
                tick;
                n++;
            end
            chk("hold_done_count", nd, 1);
        end
        chk("hold_final_ts", tsb0, 16'h0841);
        chk("hold_final_dor", dorb0, 8'h01);

        // Reset during SETTLE on driving slot 5.
        req0(3'd5, TSMUX_TS, 1'b1);
        tick;
        chk("mid_off_ts", tsb0, 16'h0041);
        tick; tick;
        rst_n = 1'b0;
        v0 = 1'b1; idx0 = 3'd5; ts0 = 2'b11; dor0 = 1'b1;
        #1;
        chk("mid_rst_ts", tsb0, 16'h0000);
        chk("mid_rst_dor", dorb0, 8'h00);
        chk("mid_rst_busy", busy0, 0);
        tick; tick;
        chk("mid_rst_done", done0, 0);
        rst_n = 1'b1;
        v0 = 1'b0;
        tick;
        chk("mid_ready", rdy0, 1);
        chk("mid_no_done", done0, 0);
        chk("mid_ts_after", tsb0, 16'h0000);

        // Slot isolation: slot i gets {tsmux,dorreg} = i.
        for (int i = 0; i < 8; i++) begin
            iv = 3'(i);
            req0(iv, iv[2:1], iv[0]);
            wait_rdy0;
            if (i == 3) begin
                chk("iso_half_ts", tsb0, 16'h0050);
                chk("iso_half_dor", dorb0, 8'h0A);
            end
        end
        chk("iso_all_ts", tsb0, 16'hFA50);
        chk("iso_all_dor", dorb0, 8'hAA);
        req0(3'd2, 2'b11, 1'b0);
        tick;
        chk("iso_off_ts", tsb0, 16'hFA40);
        chk("iso_off_dor", dorb0, 8'hAA);
        wait_rdy0;
        chk("iso_rewrite_ts", tsb0, 16'hFA70);
        chk("iso_rewrite_dor", dorb0, 8'hAA);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ioblock_cfg_ctrl.md
# ioblock_cfg_ctrl

Sequenced configuration controller for a bank of `NBLK` I/O blocks; owns each block's `TSMUX[1:0]` and `DORREG` configuration bits. Configuration requests arrive one at a time over a valid/ready handshake. Every change to a pad that is currently driving first forces that pad to tristate (`TSMUX=00`) for `SETTLE` cycles, so no pad ever glitches between drive modes. The block sits between the host configuration port and the I/O ring; its outputs feed the config inputs of the I/O blocks directly.

## Interface
- `NBLK`, default 8: number of I/O blocks managed; must be ≥2.
- `SETTLE`, default 4: cycles a pad is held at `TSMUX=00` before a new mode is applied; must be ≥1.
- `IDXW`, default `$clog2(NBLK)`: index width (localparam).
- `IOCLK`  in  1: single clock; all state updates on rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `CFG_VALID`  in  1: host request valid.
- `CFG_READY`  out  1: controller can accept a request; high only in IDLE.
- `CFG_IDX`  in  IDXW: target block index.
- `CFG_TSMUX`  in  2: requested TSMUX (00 off, 01 TS-gated, 10/11 always drive).
- `CFG_DORREG`  in  1: requested DORREG (0 = combinational input path, 1 = registered input path).
- `TSMUX_BUS`  out  2*NBLK: per-block TSMUX; block i occupies bits [2i+1:2i].
- `DORREG_BUS`  out  NBLK: per-block DORREG.
- `BUSY`  out  1: high in every state except IDLE.
- `DONE`  out  1: one-cycle pulse; request completed.
- `ERR`  out  1: one-cycle pulse; request rejected because `CFG_IDX ≥ NBLK`.

## Operation
- States: IDLE, OFF, SETTLE, APPLY, DONE, ERR.
- **IDLE**
  - Handshake fires on an edge with `CFG_VALID & CFG_READY`; the controller captures idx, tsmux and dorreg.
  - Idx out of range → ERR.
  - New config equals current config for that slot → DONE.
  - Current slot TSMUX is 00 → APPLY; the pad is already undriven, so settling is skipped.
  - Otherwise → OFF.
- **OFF**: writes 00 to the slot's TSMUX and loads the counter with `SETTLE-1`; → SETTLE.
- **SETTLE**: decrements the counter each edge; on the edge where counter==0 → APPLY.
- **APPLY**: writes the captured TSMUX and DORREG into the slot; → DONE.
- **DONE**: `DONE`=1 for exactly one cycle; → IDLE.
- **ERR**: `ERR`=1 for exactly one cycle, with no slot modified; → IDLE.
- Only the addressed slot ever changes; all other slots hold.
- Reset values:
  - all TSMUX slots 00 and all DORREG slots 0, matching I/O block power-up;
  - state IDLE, counter 0;
  - `BUSY`, `DONE`, `ERR` = 0;
  - `CFG_READY` = 1 once reset is released.
- `CFG_VALID` is ignored while `RST_N` is low.
- Reset asserted mid-sequence aborts immediately. All slots return to 00/0, including a slot that was partway through an update; no `DONE` pulse is issued.

## Timing
- Let t be the handshake edge.
- Full sequence (slot driving, config differs):
  - slot TSMUX reads 00 after edge t+1;
  - new config is visible after edge t+2+SETTLE;
  - `DONE` is high during the cycle after that edge;
  - `CFG_READY` returns after edge t+3+SETTLE.
  - With SETTLE=4: new config after t+6, READY after t+7.
- Slot already off: new config after edge t+1, `DONE` in cycle t+1..t+2, READY after t+2.
- Identical config, or out of range: `DONE`/`ERR` in cycle t..t+1, READY after t+1.
- Back-to-back requests: the next handshake can occur on the first edge where `CFG_READY`=1. There is no pipelining; at most one request is in flight.
- `DONE`, `ERR`, `BUSY` and `CFG_READY` are decoded from registered state and carry no combinational path from inputs.

## Structure
- Shared include/package `ioblock_cfg_pkg`:
  - state encodings;
  - TSMUX constants `TSMUX_OFF=2'b00`, `TSMUX_TS=2'b01`, `TSMUX_ON=2'b10`.
- The I/O block models use the same constants.
- One sub-module is natural: `ioblock_cfg_regfile`. It holds the NBLK×3-bit slot store with a single indexed write port and flattened bus outputs. The FSM and settle counter stay in the top.

## Test plan
- **Reset then full sequence.** Reset, then request idx=3, tsmux=10, dorreg=1.
  - Expected: slot 3 = 10/1 after t+1, since it was already off.
  - Then request idx=3, tsmux=01, dorreg=0 with SETTLE=4: slot 3 reads 00 during t+2..t+6, reads 01/0 after t+6, `DONE` during t+6..t+7.
- **Identical config.** Repeat idx=3, tsmux=01, dorreg=0 → `DONE` in the cycle after t, slot unchanged, no 00 interval.
- **Out-of-range index.** idx=NBLK (=8 at default width 3 this is unreachable; bench uses NBLK=6, idx=7) → `ERR` one cycle, buses unchanged.
- **Hold valid through busy.** Hold `CFG_VALID` high with differing requests during BUSY → none accepted until `CFG_READY`; each request completes in order with exactly one `DONE`.
- **Reset mid-sequence.** Assert `RST_N`=0 during SETTLE on slot 5 (driving 10) → all buses 0, no `DONE`, READY=1 after release.
- **Slot isolation.** Program all 8 slots with distinct values → each slot holds its own value; writes to one slot never disturb another.
